// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a checksummed 5-byte command-frame parser.
// Emits one-cycle register-write strobes (address + 16-bit data) for runtime control.
module uart_cmd_rx #(
    parameter int DIV     = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        cksum_err
);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [2:0] P_SYNC = 3'd0;
    localparam logic [2:0] P_ADDR = 3'd1;
    localparam logic [2:0] P_DHI  = 3'd2;
    localparam logic [2:0] P_DLO  = 3'd3;
    localparam logic [2:0] P_CK   = 3'd4;

    logic          r_sync1, r_sync2;
    logic          w_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic [7:0]    r_byte_data;
    logic          r_frame_err;

    logic [2:0]    r_pstate;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_st_addr;
    logic [15:0]   r_st_data;
    logic          r_wr_valid;
    logic [7:0]    r_wr_addr;
    logic [15:0]   r_wr_data;
    logic          r_cksum_err;
    logic [7:0]    w_cksum;

    assign w_rx_s  = r_sync2;
    assign w_cksum = r_st_addr ^ r_st_data[15:8] ^ r_st_data[7:0];

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign frame_err  = r_frame_err;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cksum_err  = r_cksum_err;

    // Bit FSM: r_cnt counts cycles since the last sample point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= rx_i;
            r_sync2      <= r_sync1;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                            r_state      <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Frame parser; byte_data is already updated in the byte_valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pstate    <= P_SYNC;
            r_to_cnt    <= '0;
            r_st_addr   <= '0;
            r_st_data   <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cksum_err <= 1'b0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_cksum_err <= 1'b0;

            if (r_byte_valid || r_pstate == P_SYNC) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_frame_err) begin
                r_pstate <= P_SYNC;
            end else if (r_byte_valid) begin
                case (r_pstate)
                    P_SYNC: begin
                        if (r_byte_data == 8'hA5) begin
                            r_pstate <= P_ADDR;
                        end
                    end
                    P_ADDR: begin
                        r_st_addr <= r_byte_data;
                        r_pstate  <= P_DHI;
                    end
                    P_DHI: begin
                        r_st_data[15:8] <= r_byte_data;
                        r_pstate        <= P_DLO;
                    end
                    P_DLO: begin
                        r_st_data[7:0] <= r_byte_data;
                        r_pstate       <= P_CK;
                    end
                    P_CK: begin
                        if (r_byte_data == w_cksum) begin
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_st_addr;
                            r_wr_data  <= r_st_data;
                        end else begin
                            r_cksum_err <= 1'b1;
                        end
                        r_pstate <= P_SYNC;
                    end
                    default: r_pstate <= P_SYNC;
                endcase
            end else if (r_pstate != P_SYNC && r_to_cnt == TW'(TIMEOUT)) begin
                r_pstate <= P_SYNC;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a bit-level line driver queues expected
// pulses with their cycle of arrival; a negedge monitor pops and compares them.
module tb_uart_cmd_rx;
    localparam int DIV     = 12;
    localparam int TIMEOUT = 4096;
    localparam int LAT     = 3 + DIV / 2 + 9 * DIV;
    localparam int K_NONE  = 0;
    localparam int K_WR    = 1;
    localparam int K_CK    = 2;

    typedef struct {
        logic [7:0]  v;
        int unsigned cyc;
    } bexp_t;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int unsigned cyc;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic        cksum_err;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    bexp_t       bq[$];
    wexp_t       wq[$];
    int unsigned fq[$];
    int unsigned cq[$];

    uart_cmd_rx #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .cksum_err (cksum_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bexp_t       b;
        wexp_t       w;
        int unsigned c;
        if (byte_valid) begin
            check("bv_pending", 32'(bq.size() != 0), 32'd1);
            if (bq.size() != 0) begin
                b = bq.pop_front();
                check("bv_data", 32'(byte_data), 32'(b.v));
                check("bv_cycle", cyc, b.cyc);
            end
        end
        if (wr_valid) begin
            check("wr_pending", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(w.a));
                check("wr_data", 32'(wr_data), 32'(w.d));
                check("wr_cycle", cyc, w.cyc);
            end
        end
        if (frame_err) begin
            check("fe_pending", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                c = fq.pop_front();
                check("fe_cycle", cyc, c);
            end
        end
        if (cksum_err) begin
            check("ck_pending", 32'(cq.size() != 0), 32'd1);
            if (cq.size() != 0) begin
                c = cq.pop_front();
                check("ck_cycle", cyc, c);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_bv"}, 32'(byte_valid), 32'd0);
        check({tag, "_bd"}, 32'(byte_data), 32'd0);
        check({tag, "_wv"}, 32'(wr_valid), 32'd0);
        check({tag, "_wa"}, 32'(wr_addr), 32'd0);
        check({tag, "_wd"}, 32'(wr_data), 32'd0);
        check({tag, "_fe"}, 32'(frame_err), 32'd0);
        check({tag, "_ce"}, 32'(cksum_err), 32'd0);
    endtask

    // Drives one 8N1 byte starting at the next negedge and queues what it should produce.
    task automatic tx_byte(input logic [7:0] b, input logic stop, input logic push,
                           input int kind, input logic [7:0] a, input logic [15:0] d,
                           input int unsigned extra_low);
        int unsigned p;
        bexp_t       be;
        wexp_t       we;
        @(negedge clk);
        rx_i = 1'b0;
        p = cyc;
        if (push) begin
            if (stop) begin
                be.v = b;
                be.cyc = p + LAT;
                bq.push_back(be);
            end else begin
                fq.push_back(p + LAT);
            end
            if (kind == K_WR) begin
                we.a = a;
                we.d = d;
                we.cyc = p + LAT + 1;
                wq.push_back(we);
            end else if (kind == K_CK) begin
                cq.push_back(p + LAT + 1);
            end
        end
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_i = stop;
        repeat (DIV) @(negedge clk);
        if (!stop) repeat (extra_low) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_byte(b, 1'b1, 1'b1, K_NONE, 8'h00, 16'h0000, 0);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] ck);
        int kind;
        kind = (ck == (a ^ d[15:8] ^ d[7:0])) ? K_WR : K_CK;
        send(8'hA5);
        send(a);
        send(d[15:8]);
        send(d[7:0]);
        tx_byte(ck, 1'b1, 1'b1, kind, a, d, 0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle(5);

        send(8'h3C);
        idle(20);

        send(8'h00);
        send(8'hFF);
        send_frame(8'h07, 16'h1234, 8'h21);
        send_frame(8'h10, 16'hBEEF, 8'h41);
        send_frame(8'h07, 16'h1234, 8'h22);
        idle(5);
        check("held_addr", 32'(wr_addr), 32'h10);
        check("held_data", 32'(wr_data), 32'hBEEF);
        send_frame(8'h22, 16'hA55A, 8'hDD);
        idle(20);

        send(8'hA5);
        tx_byte(8'h07, 1'b0, 1'b1, K_NONE, 8'h00, 16'h0000, 300);
        idle(20);
        send_frame(8'h33, 16'h0001, 8'h32);
        idle(20);

        @(negedge clk);
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(150);
        send(8'h5A);
        idle(20);

        send(8'hA5);
        send(8'h07);
        idle(TIMEOUT + 10);
        send(8'h12);
        send(8'h34);
        send(8'h21);
        idle(20);

        send(8'hA5);
        send(8'h07);
        fork
            tx_byte(8'hFF, 1'b1, 1'b0, K_NONE, 8'h00, 16'h0000, 0);
            begin
                idle(60);
                rst = 1'b1;
                @(negedge clk);
                check_all_zero("midrst");
                rst = 1'b0;
            end
        join
        idle(20);
        send_frame(8'h44, 16'h5566, 8'h77);

        idle(300);
        check("bq_empty", 32'(bq.size()), 32'd0);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("fq_empty", 32'(fq.size()), 32'd0);
        check("cq_empty", 32'(cq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receiver and command-frame parser: the receive-side counterpart of `debug_uart`, clocked from `clk_256fs` at the same `DIV` clocks per bit. It deserialises 8N1 bytes from a host, extracts checksummed 5-byte command frames, and emits one-cycle register-write strobes (address + 16-bit data). Downstream logic uses these strobes for runtime control, e.g. setting `force_dac_output` or patching calibration words without a rebuild.

## Interface

Parameters:
- `DIV`, 12, clock cycles per UART bit; must match `debug_uart`. Minimum 4.
- `TIMEOUT`, 4096, idle clock cycles allowed between bytes of one frame before the parser abandons the frame.

Ports:
- `clk`  in  1  system clock (`clk_256fs`)
- `rst`  in  1  reset, synchronous, active-high
- `rx_i`  in  1  asynchronous UART line, idle high
- `byte_valid`  out  1  one-cycle pulse; a byte was received with a good stop bit
- `byte_data`  out  8  last received byte; held until the next `byte_valid`
- `wr_valid`  out  1  one-cycle pulse; a command frame was accepted
- `wr_addr`  out  8  register address of the last accepted frame; held
- `wr_data`  out  16  register data of the last accepted frame; held
- `frame_err`  out  1  one-cycle pulse; the stop bit was sampled low
- `cksum_err`  out  1  one-cycle pulse; a frame arrived with a bad checksum

## Operation

- **Reset:** all outputs are 0. The bit FSM enters IDLE, the parser enters SYNC, and all counters clear. Both synchroniser flops reset to 1.
- **Input synchroniser:** `rx_i` passes through a 2-flop synchroniser; the result is `rx_s`. All decisions use `rx_s`. Let `HALF = DIV/2` (integer division).

Bit FSM states: IDLE, START, DATA, STOP, BREAK.
- **IDLE:** `rx_s==0` → START and load the bit counter.
- **START:** sample at `HALF` cycles after entry.
  - Sample high → IDLE. This is a glitch: no pulse is emitted.
  - Sample low → DATA.
- **DATA:** sample every `DIV` cycles. Shift in 8 bits, LSB first. After bit 7 → STOP.
- **STOP:** sample `DIV` cycles after bit 7.
  - Sample high → pulse `byte_valid`, update `byte_data` → IDLE.
  - Sample low → pulse `frame_err`, discard the byte → BREAK.
- **BREAK:** wait for `rx_s==1` → IDLE. This prevents a held-low line from generating repeated starts.

Parser states: SYNC, ADDR, DHI, DLO, CK. The parser advances only on `byte_valid`.
- **SYNC:** byte `0xA5` → ADDR; any other byte stays in SYNC silently.
- **ADDR / DHI / DLO:** latch the byte into the staging address, data[15:8] and data[7:0] respectively, then advance.
- **CK:** compare the byte with `addr ^ dhi ^ dlo`.
  - Match → pulse `wr_valid`, load `wr_addr`/`wr_data` from staging.
  - Mismatch → pulse `cksum_err`; `wr_addr`/`wr_data` are unchanged.
  - Either outcome → SYNC.

Abort rules:
- **`frame_err`:** a `frame_err` pulse in any parser state forces SYNC. Staged bytes are discarded with no further pulse.
- **Inter-byte timeout:**
  - Counter clears on every `byte_valid`; otherwise increments while the parser is not in SYNC.
  - Reaching `TIMEOUT` forces SYNC with no error pulse.
  - The counter saturates and is held at 0 while in SYNC.
- **Back-to-back frames:** accepted with no gap beyond the stop bit. A `0xA5` in an ADDR/DHI/DLO/CK position is treated as data, not as a resync.

## Timing

- **Synchroniser delay:** `rx_s` lags `rx_i` by 2 cycles.
- **Sample points:** with the first low `rx_s` at cycle t:
  - start sample at t+`HALF`
  - data bit k at t+`HALF`+(k+1)·`DIV`
  - stop sample at t+`HALF`+9·`DIV`
- **`byte_valid` / `frame_err`:** registered; assert at the stop-sample cycle + 1.
- **End-to-end byte latency:** falling edge of `rx_i` at cycle p → `byte_valid` at p+3+`HALF`+9·`DIV`. For `DIV`=12 this is p+117.
- **`wr_valid` / `cksum_err`:** assert exactly 1 cycle after the `byte_valid` of the checksum byte. `wr_addr`/`wr_data` are valid in the same cycle as `wr_valid`.
- **Pulse width:** every pulse output is high for exactly 1 cycle. At most one of `wr_valid`/`cksum_err` asserts per frame.
- **Reset mid-byte or mid-frame:** takes effect on the next clock edge and drops all partial state. The next start bit is only recognised once `rx_s` has been observed low from IDLE.

## Test plan

- **Single byte:** drive byte 0x3C, `DIV`=12, falling edge at cycle p → `byte_valid` at p+117 with `byte_data`=0x3C; `frame_err`=0.
- **Good frame:** send bytes A5 07 12 34 21 → one `wr_valid` pulse 1 cycle after the 5th `byte_valid`, with `wr_addr`=0x07 and `wr_data`=0x1234. Leading garbage bytes 00 FF before A5 → identical result.
- **Bad checksum:** send A5 07 12 34 22 → one `cksum_err` pulse and no `wr_valid`; `wr_addr`/`wr_data` keep their prior values. A following good frame is accepted.
- **Framing error:** drive the stop bit low on byte 2 of a frame → `frame_err` pulse, no `byte_valid` for that byte, parser returns to SYNC. With the line held low for 300 cycles, there is no further activity until the line goes high; a subsequent good frame is accepted.
- **Glitch:** a 3-cycle low pulse on `rx_i` → no `byte_valid`, no `frame_err`, FSM back in IDLE.
- **Timeout and reset:**
  - Send A5 07, idle `TIMEOUT`+10 cycles, then send 12 34 21 → no `wr_valid` and no `cksum_err`.
  - Assert `rst` for 1 cycle mid-DATA → all outputs read 0 the next cycle, and the next clean byte is received correctly.
